aes_block_byte_serializer: RTL

//   Downstream of the AES-128 CBC decrypt stage. Buffers 128-bit plaintext

---
 rtl/aes_block_byte_serializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/aes_block_byte_serializer.sv
// Buffers 128-bit plaintext blocks and serializes them MSB byte first onto a valid/ready byte stream.
// Optional PKCS#7 strip of the final frame block is enabled by defining PKCS7_STRIP_EN.
module aes_block_byte_serializer #(
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blk_valid,
   input  logic [127:0]     blk_data,
   input  logic             blk_last,
   output logic             blk_ready,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   input  logic             byte_ready,
   output logic             frame_done,
   output logic [CNT_W-1:0] byte_count,
   output logic             pad_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [128:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [127:0]  head_data;
   logic          head_last;
   logic [4:0]    pop_n;

   state_t        state;
   state_t        state_nxt;
   logic [127:0]  blk_q;
   logic          last_q;
   logic [3:0]    idx;
   logic [4:0]    n_q;
   logic          done_q;
   logic [CNT_W-1:0] cnt_q;
   logic          fire;
   logic          end_blk;

   // Gated by rst_n so the port reads 0 while reset is held.
   assign full      = (occ == FULL_CNT);
   assign empty     = (occ == '0);
   assign blk_ready = rst_n & ~full;
   assign push      = blk_valid & blk_ready;
   assign head_data = mem[rd_ptr][127:0];
   assign head_last = mem[rd_ptr][128];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {blk_last, blk_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

`ifdef PKCS7_STRIP_EN
   logic [7:0] pad;
   logic       pad_ok;
   logic       pad_bad;
   logic       pad_err_q;

   always_comb begin
      pad    = head_data[7:0];
      pad_ok = (pad >= 8'd1) && (pad <= 8'd16);
      for (int i = 0; i < 16; i++) begin
         if ((8'(i) < pad) && (head_data[8*i +: 8] != pad)) pad_ok = 1'b0;
      end
   end

   always_comb begin
      pop_n   = 5'd16;
      pad_bad = 1'b0;
      if (head_last) begin
         if (pad_ok) pop_n = 5'd16 - pad[4:0];
         else        pad_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pad_err_q <= 1'b0;
      else if (pop && pad_bad) pad_err_q <= 1'b1;
   end

   assign pad_err = pad_err_q;
`else
   assign pop_n   = 5'd16;
   assign pad_err = 1'b0;
`endif

   assign byte_valid = (state == SHIFT);
   assign byte_data  = blk_q[{~idx, 3'b000} +: 8];
   assign fire       = byte_valid & byte_ready;
   assign end_blk    = fire && ({1'b0, idx} == (n_q - 5'd1));
   assign frame_done = done_q;
   assign byte_count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A dropped (n=0) block is never reloaded in the same cycle a frame ends,
   // so two frame_done pulses can never coincide.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = (pop_n == 5'd0) ? IDLE : SHIFT;
            end
         end
         SHIFT: begin
            if (end_blk) begin
               if (!empty && (pop_n != 5'd0)) begin
                  pop       = 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q  <= '0;
         last_q <= 1'b0;
         idx    <= '0;
         n_q    <= '0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         done_q <= (end_blk && last_q) || (pop && (pop_n == 5'd0) && head_last);
         if (pop) begin
            blk_q  <= head_data;
            last_q <= head_last;
            idx    <= '0;
            n_q    <= pop_n;
         end else if (fire) begin
            idx <= idx + 4'd1;
         end
         if (fire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
